// File: rtl/lpc_fpga_pkg.sv
// lpc_fpga_pkg
// Shared definitions for the LPC algorithm sequencer. It holds the register
// address map, the CONTROL and STATUS bit positions, and the sequencer FSM
// state type.
package lpc_fpga_pkg;

  // Avalon-MM register addresses (word addresses)
  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_TIMEOUT = 2'd2;
  localparam logic [1:0] ADDR_CYCLES  = 2'd3;

  // CONTROL bit positions
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_ABORTED_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/lpc_seq_cycle_counter.sv
// lpc_seq_cycle_counter
// Saturating cycle counter for one sequencer run. It also flags when the
// next increment would reach the programmed limit.
// Ports:
//   clk      system clock
//   srst_i   synchronous active-high reset
//   clear_i  force the count to 0 (wins over enable_i)
//   enable_i count this cycle; holds at all-ones
//   limit_i  terminal limit; 0 disables the match
//   count_o  current count
//   match_o  high when limit_i != 0 and count_o + 1 == limit_i
module lpc_seq_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst_i,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         match_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The comparison uses count+1, so the cycle that reaches the limit is the
  // last one counted. A saturated count wraps to 0 here and can never match
  // a nonzero limit.
  assign match_o = (limit_i != '0) && ((count_q + W'(1)) == limit_i);
  assign count_o = count_q;

endmodule

// File: rtl/lpc_algorithm_sequencer.sv
// lpc_algorithm_sequencer
// Avalon-MM slave that runs the LPC algorithm datapath once per start
// command. It holds alg_run high until one of these ends the run: alg_done,
// an abort write, or the cycle timeout.
// Optional feature macro: LPC_SEQ_IRQ_EN adds CONTROL.irq_en and the irq output.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   address, chipselect,  Avalon-MM slave; a write is chipselect & ~write_n
//   write_n, writedata
//   readdata              combinational read data (latency 0)
//   alg_done              datapath completion strobe (sampled in RUN only)
//   alg_run               run level to the datapath
//   irq                   level interrupt (LPC_SEQ_IRQ_EN only)
module lpc_algorithm_sequencer
  import lpc_fpga_pkg::*;
#(
  parameter int          TIMEOUT_W       = 32,
  parameter int unsigned DEFAULT_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        alg_done,
  output logic        alg_run
`ifdef LPC_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  seq_state_e state_q, state_d;

  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 abt_q, abt_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;

  logic                 reg_wr;
  logic                 start_req;
  logic                 abort_req;
  logic                 status_wr;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic                 cnt_match;
  logic [TIMEOUT_W-1:0] cnt_value;
  logic                 set_done, set_tmo, set_abt, clr_status;
  logic                 busy;

  assign reg_wr    = chipselect & ~write_n;
  assign start_req = reg_wr && (address == ADDR_CONTROL) && writedata[CTRL_START_BIT];
  assign abort_req = reg_wr && (address == ADDR_CONTROL) && writedata[CTRL_ABORT_BIT];
  assign status_wr = reg_wr && (address == ADDR_STATUS);
  assign busy      = (state_q != IDLE);
  assign alg_run   = (state_q == RUN);

  lpc_seq_cycle_counter #(
    .W (TIMEOUT_W)
  ) u_cycle_counter (
    .clk      (clk),
    .srst_i   (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .limit_i  (limit_q),
    .count_o  (cnt_value),
    .match_o  (cnt_match)
  );

  // Next-state logic. The run-exit causes are checked in priority order:
  // done first, then abort, then timeout.
  always_comb begin
    state_d    = state_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    set_done   = 1'b0;
    set_tmo    = 1'b0;
    set_abt    = 1'b0;
    clr_status = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d    = RUN;
          cnt_clear  = 1'b1;
          clr_status = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (alg_done) begin
          set_done = 1'b1;
          state_d  = STOP;
        end else if (abort_req) begin
          set_abt = 1'b1;
          state_d = STOP;
        end else if (cnt_match) begin
          set_tmo = 1'b1;
          state_d = STOP;
        end
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky status bits. They are cleared on start or by a W1C write. A
  // hardware set in the same cycle overrides the W1C clear.
  always_comb begin
    done_d = done_q;
    tmo_d  = tmo_q;
    abt_d  = abt_q;
    if (clr_status) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
      abt_d  = 1'b0;
    end else if (status_wr) begin
      done_d = done_q & ~writedata[STAT_DONE_BIT];
      tmo_d  = tmo_q  & ~writedata[STAT_TIMEOUT_BIT];
      abt_d  = abt_q  & ~writedata[STAT_ABORTED_BIT];
    end
    done_d = done_d | set_done;
    tmo_d  = tmo_d  | set_tmo;
    abt_d  = abt_d  | set_abt;
  end

  // The limit can be rewritten at any time. A write during RUN affects the
  // very next match check.
  always_comb begin
    limit_d = limit_q;
    if (reg_wr && (address == ADDR_TIMEOUT)) begin
      limit_d = writedata[TIMEOUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      abt_q   <= 1'b0;
      limit_q <= TIMEOUT_W'(DEFAULT_TIMEOUT);
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      abt_q   <= abt_d;
      limit_q <= limit_d;
    end
  end

`ifdef LPC_SEQ_IRQ_EN
  logic irq_en_q, irq_en_d;

  // Every CONTROL write reloads irq_en, including start and abort writes.
  always_comb begin
    irq_en_d = irq_en_q;
    if (reg_wr && (address == ADDR_CONTROL)) begin
      irq_en_d = writedata[CTRL_IRQ_EN_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
    end
  end

  assign irq = irq_en_q & (done_q | tmo_q | abt_q);
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CONTROL: begin
`ifdef LPC_SEQ_IRQ_EN
        readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
      end
      ADDR_STATUS: begin
        readdata[STAT_BUSY_BIT]    = busy;
        readdata[STAT_DONE_BIT]    = done_q;
        readdata[STAT_TIMEOUT_BIT] = tmo_q;
        readdata[STAT_ABORTED_BIT] = abt_q;
      end
      ADDR_TIMEOUT: readdata[TIMEOUT_W-1:0] = limit_q;
      ADDR_CYCLES:  readdata[TIMEOUT_W-1:0] = cnt_value;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: doc/lpc_algorithm_sequencer.md
# lpc_algorithm_sequencer

Avalon-MM slave that sequences one run of the LPC algorithm datapath: software writes a start command, the block asserts the run level to the datapath, waits for the datapath's done strobe, and enforces an optional cycle timeout. It also reports busy, done, timeout and abort status, and the cycle count of the last run. It sits in the Qsys system between the Nios data master and the LPC algorithm core, where it takes the place of a bare run-flag PIO.

## Interface
Parameters:
- TIMEOUT_W, 32: width of the timeout limit and cycle counter, 1..32.
- DEFAULT_TIMEOUT, 1000000: reset value of the TIMEOUT register; 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe. A write occurs when chipselect & ~write_n.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address (read latency 0). Unused bits read 0.
- alg_done  in  1  datapath completion strobe. Sampled only in RUN.
- alg_run  out  1  run level to the datapath.
- irq  out  1  interrupt. Present only with LPC_SEQ_IRQ_EN.

## Operation
Register map:
- Address 0, CONTROL.
  - Write: bit0 = 1 requests start. bit1 = 1 requests abort. bit2 = irq_en (macro only).
  - Read: bit2 = irq_en. Other bits read 0.
- Address 1, STATUS.
  - bit0 busy (read-only, high in RUN and STOP).
  - bit1 done, bit2 timeout, bit3 aborted: all sticky, write-1-to-clear.
- Address 2, TIMEOUT: limit in cycles, read/write, TIMEOUT_W bits. A write while busy takes effect immediately.
- Address 3, CYCLES: read-only count of RUN cycles for the current or last run.

FSM states IDLE, RUN, STOP:
- IDLE → RUN on a start write. On the same edge: CYCLES cleared to 0, done/timeout/aborted cleared.
- RUN: CYCLES increments every cycle and saturates at all-ones. Leave RUN for STOP on the first of these to occur, with this priority:
  - alg_done=1 sets done.
  - An abort write sets aborted.
  - TIMEOUT≠0 and CYCLES+1==TIMEOUT sets timeout.
- STOP → IDLE unconditionally after one cycle. This guarantees the datapath sees at least one low cycle between runs.

Rules:
- alg_run = (state==RUN).
- A start write while busy is ignored and has no side effects.
- An abort write in IDLE or STOP is ignored.
- A start and an abort in the same write: in IDLE, start wins; in RUN, abort wins.
- If a W1C write and a hardware set of the same status bit happen in the same cycle, the set wins.
- Reset mid-run returns to IDLE immediately; alg_run drops on the reset edge.

Reset values:
- state IDLE; alg_run 0; readdata per the register contents.
- STATUS 0; CYCLES 0; TIMEOUT DEFAULT_TIMEOUT; irq_en 0; irq 0.

## Timing
- Start write sampled at edge N: alg_run=1 and busy=1 from N+1.
- alg_done high at edge M while in RUN: alg_run=0 and done=1 from M+1; busy=0 from M+2.
- CYCLES after completion = number of cycles alg_run was high.
- Timeout with TIMEOUT=T: alg_run is high for exactly T cycles, then timeout=1.
- Earliest accepted restart: the start write is sampled at M+2 (first IDLE edge); a write sampled at M+1, during STOP, is ignored.
- readdata reflects register state combinationally in the same cycle.

## Configuration
- LPC_SEQ_IRQ_EN defined:
  - CONTROL bit2 implements irq_en.
  - irq = irq_en & (done | timeout | aborted), driven from registers only, no combinational path from inputs.
- LPC_SEQ_IRQ_EN undefined:
  - The irq port is absent.
  - CONTROL bit2 is not implemented and reads 0.
  - All other behaviour is identical.

## Structure
- Shared package lpc_fpga_pkg holds:
  - register address constants (ADDR_CONTROL=0, ADDR_STATUS=1, ADDR_TIMEOUT=2, ADDR_CYCLES=3);
  - CONTROL/STATUS bit-index constants;
  - the FSM state typedef (IDLE, RUN, STOP).
- One sub-module, lpc_seq_cycle_counter: a saturating TIMEOUT_W counter with clear, enable, and a terminal-match output against the limit. The register file and FSM stay in the top module.

## Test plan
- After reset, read all four addresses → 0, 0, 1000000, 0; alg_run=0.
- Write CONTROL=1, pulse alg_done 10 cycles after alg_run rises → alg_run high 10 cycles, STATUS=0x2, CYCLES=10, busy clears 2 cycles after the done strobe.
- TIMEOUT=5, start, hold alg_done=0 → alg_run high exactly 5 cycles, STATUS=0x4, CYCLES=5.
- Start with TIMEOUT=0; abort after 20 cycles; in the same run a second start during RUN → STATUS=0x8, CYCLES=20, second start has no effect.
- alg_done and abort in the same RUN cycle → done=1, aborted=0. Then W1C write 0xE to STATUS in the same cycle as a new done set → done remains 1.
- LPC_SEQ_IRQ_EN defined, CONTROL=0x4 then start and complete → irq=1 from the cycle after done; writing STATUS=0x2 → irq=0. Reset mid-run → alg_run=0 on the next edge.
